// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execution unit: register width, opcodes,
// front-end pst codes and the internal FSM state type.
package exec_unit_pkg;

  localparam int unsigned REG_W    = 4;
  localparam int unsigned NUM_REGS = 16;

  // Front-end FSM state codes as seen on the pst input
  typedef enum logic [3:0] {
    PST_IDLE = 4'b0000,
    PST_OP   = 4'b1000,
    PST_RD1  = 4'b0100,
    PST_RD2  = 4'b0010,
    PST_WR   = 4'b0001,
    PST_EXEC = 4'b1110,
    PST_DONE = 4'b1111
  } pst_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_INC  = 4'h9,
    OP_DEC  = 4'hA,
    OP_MOV  = 4'hB,
    OP_LDI  = 4'hC,
    OP_CMP  = 4'hD,
    OP_SLT  = 4'hE,
    OP_NOP2 = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  // True for the opcodes that leave result, flags and registers untouched
  function automatic logic is_nop(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_NOP2);
  endfunction

endpackage

// File: rtl/exec_unit_alu4.sv
// alu4: purely combinational 4-bit ALU. Every operation is evaluated in a
// 5-bit intermediate whose top bit is the carry/borrow/shifted-out bit.
module alu4
  import exec_unit_pkg::*;
(
  input  logic [3:0]       op,
  input  logic [REG_W-1:0] a,
  input  logic [REG_W-1:0] b,
  input  logic [REG_W-1:0] imm,
  output logic [REG_W-1:0] result,
  output logic             carry
);

  logic [REG_W:0] wide;

  // Opcode decode; ops without a carry leave the top bit zero
  always_comb begin
    wide = '0;
    case (op_e'(op))
      OP_ADD:         wide = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: wide = {1'b0, a} - {1'b0, b};
      OP_AND:         wide = {1'b0, a & b};
      OP_OR:          wide = {1'b0, a | b};
      OP_XOR:         wide = {1'b0, a ^ b};
      OP_NOT:         wide = {1'b0, ~a};
      OP_SHL:         wide = {a, 1'b0};
      OP_SHR:         wide = {a[0], 1'b0, a[REG_W-1:1]};
      OP_INC:         wide = {1'b0, a} + 5'd1;
      OP_DEC:         wide = {1'b0, a} - 5'd1;
      OP_MOV:         wide = {1'b0, a};
      OP_LDI:         wide = {1'b0, imm};
      OP_SLT:         wide = {{REG_W{1'b0}}, (a < b)};
      default:        wide = '0;
    endcase
    result = wide[REG_W-1:0];
    carry  = wide[REG_W];
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: 16 x 4-bit register file plus a four-state sequencer that
// launches one instruction per EXEC entry of the front-end FSM.
module exec_unit
  import exec_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       pst,
  input  logic [15:0]      instruction,
  output logic [REG_W-1:0] alu_result,
  output logic             result_valid,
  output logic             busy,
  output logic             zero_flag,
  output logic             carry_flag
);

  state_e           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [REG_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [REG_W-1:0] alu_result_q, alu_result_d;
  logic             zero_q, zero_d, carry_q, carry_d;
  logic             valid_q, valid_d, busy_q, busy_d;
  logic [3:0]       pst_prev_q, pst_prev_d;
  logic [REG_W-1:0] regs_q [NUM_REGS];
  logic [REG_W-1:0] regs_d [NUM_REGS];

  logic [3:0]       op, ra, rb, rw;
  logic [REG_W-1:0] alu_res;
  logic             alu_carry;
  logic             start;

  assign op = instr_q[15:12];
  assign ra = instr_q[11:8];
  assign rb = instr_q[7:4];
  assign rw = instr_q[3:0];

  assign start = (pst == PST_EXEC) && (pst_prev_q != PST_EXEC);

  alu4 u_alu (
    .op     (op),
    .a      (a_q),
    .b      (b_q),
    .imm    (ra),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // Next-state logic for sequencer, operand latches, outputs and register file.
  // Visible outputs load on the EXEC->WB edge so they are valid during the WB
  // cycle alongside result_valid; the register write lands at the end of WB.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    alu_result_d = alu_result_q;
    zero_d       = zero_q;
    carry_d      = carry_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    pst_prev_d   = pst;
    regs_d       = regs_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          instr_d = instruction;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = regs_q[ra];
        b_d     = regs_q[rb];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_res;
        valid_d = 1'b1;
        if (!is_nop(op)) begin
          zero_d  = (alu_res == '0);
          carry_d = alu_carry;
          if (op != OP_CMP) alu_result_d = alu_res;
        end
        state_d = S_WB;
      end
      S_WB: begin
        if (!is_nop(op) && (op != OP_CMP)) regs_d[rw] = res_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      alu_result_q <= '0;
      zero_q       <= 1'b1;
      carry_q      <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      pst_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      pst_prev_q   <= pst_prev_d;
    end
  end

  // Register file; reset preloads each register with its own index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_W'(i);
    end else begin
      regs_q <= regs_d;
    end
  end

  assign alu_result   = alu_result_q;
  assign zero_flag    = zero_q;
  assign carry_flag   = carry_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule
